// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if;
  logic        p0_req, p0_we, p0_gnt, p0_stall, p0_rvalid;
  logic [1:0]  p0_store;
  logic [2:0]  p0_load;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_lock, p1_we, p1_gnt, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_we;
  logic [1:0]  mem_store;
  logic [2:0]  mem_load;
  logic [31:0] mem_wa, mem_wd, mem_rd;
  modport slave (
    input  p0_req, p0_we, p0_store, p0_load, p0_addr, p0_wdata,
    input  p1_req, p1_lock, p1_we, p1_addr, p1_wdata, mem_rd,
    output p0_gnt, p0_stall, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_wa, mem_wd, mem_store, mem_load
  );
  modport master (
    output p0_req, p0_we, p0_store, p0_load, p0_addr, p0_wdata,
    output p1_req, p1_lock, p1_we, p1_addr, p1_wdata, mem_rd,
    input  p0_gnt, p0_stall, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
    input  mem_we, mem_wa, mem_wd, mem_store, mem_load
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority two-port data-memory arbiter with port-1 starvation guard and burst lock
module dmem_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input logic        clk,
  input logic        rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {FREE, LOCK} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [31:0]       p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic              starved, g0, g1;
  always_comb begin
    starved     = bus.p1_req && (cnt_q == CNT_W'(STARVE_MAX));
    // grants are forced low while reset is held
    g1          = rst_n && bus.p1_req && (state_q == LOCK || starved || !bus.p0_req);
    g0          = rst_n && state_q == FREE && bus.p0_req && !starved;
    state_d     = (g1 && bus.p1_lock) ? LOCK : FREE;
    cnt_d       = g1 ? '0 : (bus.p1_req && cnt_q != CNT_W'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
    p0_rvalid_d = g0;
    p1_rvalid_d = g1;
    p0_rdata_d  = (g0 && !bus.p0_we) ? bus.mem_rd : p0_rdata_q;
    p1_rdata_d  = (g1 && !bus.p1_we) ? bus.mem_rd : p1_rdata_q;
  end
  assign bus.p0_gnt    = g0;
  assign bus.p1_gnt    = g1;
  assign bus.p0_stall  = bus.p0_req && !g0;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.mem_we    = g0 ? bus.p0_we : (g1 && bus.p1_we);
  assign bus.mem_wa    = g0 ? bus.p0_addr : g1 ? bus.p1_addr : '0;
  assign bus.mem_wd    = g0 ? bus.p0_wdata : g1 ? bus.p1_wdata : '0;
  assign bus.mem_store = g0 ? bus.p0_store : 2'b00;
  assign bus.mem_load  = g0 ? bus.p0_load : 3'b000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FREE;
      cnt_q       <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int SM = 8;
  logic clk, rst_n;
  dmem_arbiter_if bus ();
  dmem_arbiter #(.STARVE_MAX(SM), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int total = 0, bad = 0;
  logic [31:0] mem [16];
  bit          m_lock, m_rv0, m_rv1;
  int          m_wait;
  logic [31:0] m_rd0, m_rd1;
  logic        s_g0, s_g1, s_st0, s_rv0, s_rv1;
  logic [31:0] s_rd0, s_rd1;
  logic [1:0]  s_store;
  logic [2:0]  s_load;
  bit          w_pend;
  logic [31:0] w_a, w_d;
  logic [1:0]  w_s;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [31:0] sized(input logic [31:0] w, input logic [1:0] off, input logic [2:0] ld);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (ld)
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b010:  return {{24{s[7]}}, s[7:0]};
      3'b011:  return {16'b0, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      default: return w;
    endcase
  endfunction
  always_comb bus.mem_rd = sized(mem[bus.mem_wa[5:2]], bus.mem_wa[1:0], bus.mem_load);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mem_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
    logic [3:0]  be;
    logic [31:0] d;
    be = s == 2'd0 ? 4'hF : s == 2'd1 ? (4'h3 << a[1:0]) : (4'h1 << a[1:0]);
    d  = s == 2'd0 ? wd : s == 2'd1 ? {2{wd[15:0]}} : {4{wd[7:0]}};
    for (int b = 0; b < 4; b++) if (be[b]) mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic model_reset();
    m_lock = 0; m_wait = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
  endtask
  // Who owns the memory this cycle, derived from priority, starvation wait and burst ownership
  task automatic model_step();
    bit e0, e1, ewe;
    logic [31:0] ewa, ewd;
    e0 = 0; e1 = 0;
    if (rst_n) begin
      if (m_lock) e1 = bus.p1_req;
      else if (bus.p1_req && m_wait >= SM) e1 = 1;
      else if (bus.p0_req) e0 = 1;
      else e1 = bus.p1_req;
    end
    ewe = e0 ? bus.p0_we : e1 ? bus.p1_we : 1'b0;
    ewa = e0 ? bus.p0_addr : e1 ? bus.p1_addr : 32'h0;
    ewd = e0 ? bus.p0_wdata : e1 ? bus.p1_wdata : 32'h0;
    chk("p0_gnt", bus.p0_gnt, e0);
    chk("p1_gnt", bus.p1_gnt, e1);
    chk("p0_stall", bus.p0_stall, bus.p0_req && !e0);
    chk("mem_we", bus.mem_we, ewe);
    chk("mem_wa", bus.mem_wa, ewa);
    chk("mem_wd", bus.mem_wd, ewd);
    chk("mem_store", bus.mem_store, e0 ? bus.p0_store : 2'b00);
    chk("mem_load", bus.mem_load, e0 ? bus.p0_load : 3'b000);
    chk("p0_rvalid", bus.p0_rvalid, m_rv0);
    chk("p0_rdata", bus.p0_rdata, m_rd0);
    chk("p1_rvalid", bus.p1_rvalid, m_rv1);
    chk("p1_rdata", bus.p1_rdata, m_rd1);
    s_g0 = bus.p0_gnt; s_g1 = bus.p1_gnt; s_st0 = bus.p0_stall;
    s_rv0 = bus.p0_rvalid; s_rv1 = bus.p1_rvalid; s_rd0 = bus.p0_rdata; s_rd1 = bus.p1_rdata;
    s_store = bus.mem_store; s_load = bus.mem_load;
    w_pend = ewe; w_a = ewa; w_d = ewd; w_s = e0 ? bus.p0_store : 2'b00;
    if (!rst_n) model_reset();
    else begin
      if (e0 && !bus.p0_we) m_rd0 = sized(mem[bus.p0_addr[5:2]], bus.p0_addr[1:0], bus.p0_load);
      if (e1 && !bus.p1_we) m_rd1 = mem[bus.p1_addr[5:2]];
      m_rv0  = e0;
      m_rv1  = e1;
      m_lock = e1 && bus.p1_lock;
      m_wait = e1 ? 0 : bus.p1_req ? (m_wait < SM ? m_wait + 1 : SM) : m_wait;
    end
  endtask
  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (w_pend) mem_write(w_a, w_d, w_s);
  endtask
  task automatic new_p0();
    logic [1:0]  sz;
    logic [31:0] a;
    sz = 2'($urandom_range(0, 2));
    a  = $urandom;
    bus.p0_req   = ($urandom_range(0, 2) != 0);
    bus.p0_we    = 1'($urandom_range(0, 1));
    bus.p0_store = sz;
    bus.p0_load  = sz == 2'd0 ? 3'b000 : sz == 2'd1 ? ($urandom_range(0, 1) != 0 ? 3'b001 : 3'b011)
                                                    : ($urandom_range(0, 1) != 0 ? 3'b010 : 3'b100);
    bus.p0_addr  = {26'b0, a[5:0]} & (sz == 2'd0 ? ~32'h3 : sz == 2'd1 ? ~32'h1 : ~32'h0);
    bus.p0_wdata = $urandom;
  endtask
  task automatic new_p1();
    logic [31:0] a;
    a = $urandom;
    bus.p1_req   = ($urandom_range(0, 1) != 0);
    bus.p1_lock  = ($urandom_range(0, 2) == 0);
    bus.p1_we    = 1'($urandom_range(0, 1));
    bus.p1_addr  = {26'b0, a[5:2], 2'b00};
    bus.p1_wdata = $urandom;
  endtask
  task automatic set_p0(input logic req, input logic we, input logic [2:0] ld, input logic [31:0] a);
    bus.p0_req = req; bus.p0_we = we; bus.p0_load = ld; bus.p0_store = 2'b00; bus.p0_addr = a;
    bus.p0_wdata = 32'h0;
  endtask
  task automatic set_p1(input logic req, input logic lock, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.p1_req = req; bus.p1_lock = lock; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
  endtask
  initial begin
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[4] = 32'h0000_00A5;
    set_p0(1, 0, 3'b000, 32'h0);
    set_p1(1, 0, 0, 32'h4, 32'h0);
    step();
    step();
    chk("rst_p0_gnt", s_g0, 0);
    chk("rst_p1_gnt", s_g1, 0);
    chk("rst_p0_rvalid", s_rv0, 0);
    set_p0(0, 0, 3'b000, 32'h0);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    rst_n = 1;
    step();
    set_p0(1, 0, 3'b010, 32'h10);
    step();
    chk("lb_gnt", s_g0, 1);
    chk("lb_mem_load", s_load, 3'b010);
    set_p0(0, 0, 3'b000, 32'h0);
    step();
    chk("lb_rvalid", s_rv0, 1);
    chk("lb_rdata", s_rd0, 32'hFFFF_FFA5);
    set_p1(1, 0, 1, 32'h20, 32'hDEAD_BEEF);
    step();
    chk("p1w_gnt", s_g1, 1);
    chk("p1w_store", s_store, 2'b00);
    set_p1(1, 0, 0, 32'h20, 32'h0);
    step();
    chk("p1r_gnt", s_g1, 1);
    chk("p1w_rvalid", s_rv1, 1);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    step();
    chk("p1r_rvalid", s_rv1, 1);
    chk("p1r_rdata", s_rd1, 32'hDEAD_BEEF);
    set_p0(1, 0, 3'b000, 32'h0);
    set_p1(1, 0, 0, 32'h4, 32'h0);
    for (int i = 0; i < SM; i++) begin
      step();
      chk("starve_p0_gnt", s_g0, 1);
      chk("starve_p0_stall", s_st0, 0);
    end
    step();
    chk("starve_p1_gnt", s_g1, 1);
    chk("starve_p0_stall9", s_st0, 1);
    step();
    chk("starve_p0_resume", s_g0, 1);
    set_p1(1, 1, 1, 32'h30, 32'h1111_0001);
    for (int i = 0; i < 20 && !s_g1; i++) step();
    chk("burst_start", s_g1, 1);
    for (int b = 1; b < 4; b++) begin
      set_p1(1, b < 3, 1, 32'h30 + 32'(4 * b), 32'h1111_0001 + 32'(b));
      step();
      chk("burst_p1_gnt", s_g1, 1);
      chk("burst_p0_gnt", s_g0, 0);
    end
    set_p1(0, 0, 0, 32'h0, 32'h0);
    step();
    chk("burst_after_p0", s_g0, 1);
    chk("burst_mem", mem[15], 32'h1111_0004);
    set_p0(0, 0, 3'b000, 32'h0);
    set_p1(1, 1, 0, 32'h8, 32'h0);
    step();
    chk("abandon_p1_gnt", s_g1, 1);
    set_p1(0, 0, 0, 32'h0, 32'h0);
    set_p0(1, 0, 3'b000, 32'h0);
    step();
    chk("abandon_p0_held", s_g0, 0);
    chk("abandon_stall", s_st0, 1);
    step();
    chk("abandon_p0_gnt", s_g0, 1);
    set_p0(0, 0, 3'b000, 32'h0);
    set_p1(1, 1, 0, 32'h20, 32'h0);
    step();
    chk("mid_pre_rvalid", bus.p1_rvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_p1_rvalid", bus.p1_rvalid, 0);
    chk("mid_rst_p1_rdata", bus.p1_rdata, 0);
    chk("mid_rst_p0_rdata", bus.p0_rdata, 0);
    model_reset();
    set_p0(1, 0, 3'b000, 32'h0);
    step();
    rst_n = 1;
    step();
    chk("post_rst_p0_first", s_g0, 1);
    chk("post_rst_p1", s_g1, 0);
    for (int i = 0; i < 3000; i++) begin
      if (s_g0 || !bus.p0_req) new_p0();
      if (s_g1 || !bus.p1_req) new_p1();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data-memory wrapper (sized store/load port), in the MEM stage.
- Port 0 is the pipeline load/store unit; port 1 is the program loader/debug master (word-only, with optional bus lock for bursts).
- Fixed priority to port 0, a starvation guard for port 1, a lock state machine, and registered per-port read responses.

Parameters:
- STARVE_MAX, 8, consecutive denied cycles after which port 1 outranks port 0 (min 1)
- CNT_W, 4, width of starvation counter (must hold STARVE_MAX)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- p0_req  input  1  port 0 request valid, held until granted
- p0_we  input  1  port 0 write (1) / read (0)
- p0_store  input  2  store size: 00 word, 01 half, 10 byte
- p0_load  input  3  load type: 000 word, 001 LH, 010 LB, 011 LHU, 100 LBU
- p0_addr  input  32  port 0 byte address
- p0_wdata  input  32  port 0 write data
- p0_gnt  output  1  port 0 granted this cycle (combinational)
- p0_stall  output  1  p0_req & ~p0_gnt, to pipeline hazard unit
- p0_rvalid  output  1  port 0 response, one cycle after grant
- p0_rdata  output  32  port 0 registered read data
- p1_req  input  1  port 1 request valid, held until granted
- p1_lock  input  1  keep bus after this beat
- p1_we  input  1  port 1 write / read (word only)
- p1_addr  input  32  port 1 byte address
- p1_wdata  input  32  port 1 write data
- p1_gnt  output  1  port 1 granted this cycle
- p1_rvalid  output  1  port 1 response, one cycle after grant
- p1_rdata  output  32  port 1 registered read data
- mem_we  output  1  memory write enable
- mem_wa  output  32  memory address
- mem_wd  output  32  memory write data
- mem_store  output  2  store size to memory
- mem_load  output  3  load type to memory
- mem_rd  input  32  memory read data (combinational, already sized)

Behaviour:
- Reset (async, rst_n=0): state FREE, starve_cnt=0, p0/p1_rvalid=0, p0/p1_rdata=0; grants 0 while in reset.
- States: FREE, LOCK.
- FREE grant rule:
  - p1 wins if p1_req & (starve_cnt==STARVE_MAX).
  - Otherwise p0 wins if p0_req.
  - Otherwise p1 wins if p1_req.
  - At most one grant per cycle.
- LOCK: only p1 can be granted; p0_gnt=0 regardless of p0_req.
- Transitions:
  - FREE->LOCK on p1_gnt & p1_lock.
  - LOCK->FREE on p1_gnt & ~p1_lock (last beat), or on p1_req=0 (abandoned burst).
  - LOCK stays on p1_gnt & p1_lock.
- Starvation counter:
  - Increments by 1 each cycle p1_req & ~p1_gnt; saturates at STARVE_MAX.
  - Cleared to 0 on p1_gnt.
  - Holds when p1_req=0.
- Memory mux, driven in the grant cycle:
  - p0 grant: mem_* = p0 fields; mem_we=p0_we.
  - p1 grant: mem_wa=p1_addr, mem_wd=p1_wdata, mem_we=p1_we, mem_store=00, mem_load=000.
  - No grant: mem_we=0, mem_wa=0, mem_wd=0, mem_store=00, mem_load=000.
- Latency:
  - Grant in cycle T; write committed at the T->T+1 edge.
  - For reads, mem_rd is captured into the granted port's rdata at that edge.
  - rvalid is high for exactly cycle T+1, for reads and writes.
  - rdata is unchanged by writes.
- Back-to-back: a port may re-request in T+1; every cycle can carry one transaction.
- Requesters must hold their fields stable while req=1 & gnt=0; the arbiter does not latch them.
- Simultaneous p0_req & p1_req with starve_cnt<STARVE_MAX: p0 granted, counter increments.

Test Plan:
- p0 read addr 0x10 (mem holds 0x000000A5), p0_load=010, no p1 -> p0_gnt same cycle, mem_load=010, next cycle p0_rvalid=1, p0_rdata=0xFFFFFFA5.
- p1 write 0x20<-0xDEADBEEF with p0 idle, then p1 read 0x20 -> p1_rvalid pulses twice; second p1_rdata=0xDEADBEEF; mem_store=00 on both.
- p0_req and p1_req held high continuously, STARVE_MAX=8 -> p0 granted 8 cycles with p0_stall=0; 9th cycle p1_gnt=1, p0_stall=1; counter returns to 0; p0 resumes next cycle.
- p1 burst of 4 writes, lock=1 on beats 1-3 and 0 on beat 4, p0_req high throughout -> p0_gnt=0 for all 4 beats; p0 granted in the cycle after beat 4.
- Lock abandoned: p1 beat with lock=1, then p1_req=0 for one cycle with p0_req=1 -> that cycle p0 is not granted (still LOCK), state returns to FREE, p0 granted the following cycle.
- rst_n asserted mid-burst in LOCK with p1_rvalid=1 -> all rvalid/rdata/starve_cnt=0 immediately; after release, state FREE and p0 granted first.
